// File: rtl/islem_denetleyici.sv
// islem_denetleyici: operation sequencer in front of the seven calculator units.
//   Takes one request (operands + op code) over istek_gecerli/istek_hazir. It pulses the
//   selected unit's start and waits for that unit's ready flag, with a timeout. It then
//   captures the result and holds it until the consumer takes it with sonuc_al.
// Ports:
//   clk, rst                       clock (rising edge), asynchronous active-high reset
//   istek_gecerli / istek_hazir    request handshake
//   sayi1, sayi2, tur              operands and op code (111 = invalid), sampled on accept
//   birim_sayi1/2, birim_basla     latched operands and one-hot start pulse to the units
//   birim_hazir/gecerli/tasma      per-unit done / result-valid / overflow flags
//   birim_sonuc                    unit k result at [64k+63:64k]
//   sonuc, gecerli, tasma          captured result and flags
//   zaman_asimi                    operation aborted by timeout
//   hazir / sonuc_al               result available / consumer takes result
module islem_denetleyici #(
    parameter int unsigned ZAMAN_ASIMI = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         istek_gecerli,
    output logic         istek_hazir,
    input  logic [31:0]  sayi1,
    input  logic [31:0]  sayi2,
    input  logic [2:0]   tur,
    output logic [31:0]  birim_sayi1,
    output logic [31:0]  birim_sayi2,
    output logic [6:0]   birim_basla,
    input  logic [6:0]   birim_hazir,
    input  logic [6:0]   birim_gecerli,
    input  logic [6:0]   birim_tasma,
    input  logic [447:0] birim_sonuc,
    output logic [63:0]  sonuc,
    output logic         gecerli,
    output logic         tasma,
    output logic         zaman_asimi,
    output logic         hazir,
    input  logic         sonuc_al
);

    localparam int unsigned SayacW = $clog2(ZAMAN_ASIMI) + 1;
    localparam logic [SayacW-1:0] SayacSon = SayacW'(ZAMAN_ASIMI - 1);

    typedef enum logic [1:0] {StBosta, StBaslat, StBekle, StCikis} durum_e;

    durum_e             durum_q, durum_d;
    logic [SayacW-1:0]  sayac_q, sayac_d;
    logic [2:0]         tur_q, tur_d;
    logic [31:0]        sayi1_q, sayi1_d, sayi2_q, sayi2_d;
    logic [6:0]         basla_q, basla_d;
    logic [63:0]        sonuc_q, sonuc_d;
    logic               gecerli_q, gecerli_d, tasma_q, tasma_d;
    logic               zaman_q, zaman_d, hazir_q, hazir_d;
    logic               istek_hazir_q, istek_hazir_d;

    // Signals of the unit selected by the latched op code
    logic        sec_hazir, sec_gecerli, sec_tasma;
    logic [63:0] sec_sonuc;

    always_comb begin
        sec_hazir   = 1'b0;
        sec_gecerli = 1'b0;
        sec_tasma   = 1'b0;
        sec_sonuc   = '0;
        for (int unsigned k = 0; k < 7; k++) begin
            if (tur_q == 3'(k)) begin
                sec_hazir   = birim_hazir[k];
                sec_gecerli = birim_gecerli[k];
                sec_tasma   = birim_tasma[k];
                sec_sonuc   = birim_sonuc[64*k +: 64];
            end
        end
    end

    always_comb begin
        durum_d   = durum_q;
        sayac_d   = sayac_q;
        tur_d     = tur_q;
        sayi1_d   = sayi1_q;
        sayi2_d   = sayi2_q;
        basla_d   = '0;
        sonuc_d   = sonuc_q;
        gecerli_d = gecerli_q;
        tasma_d   = tasma_q;
        zaman_d   = zaman_q;

        unique case (durum_q)
            StBosta: begin
                if (istek_gecerli && istek_hazir_q) begin
                    sayi1_d = sayi1;
                    sayi2_d = sayi2;
                    tur_d   = tur;
                    if (tur == 3'b111) begin
                        sonuc_d   = '0;
                        gecerli_d = 1'b0;
                        tasma_d   = 1'b0;
                        zaman_d   = 1'b0;
                        durum_d   = StCikis;
                    end else begin
                        // Start is registered so it is high exactly while in StBaslat
                        basla_d = 7'(1) << tur;
                        durum_d = StBaslat;
                    end
                end
            end
            StBaslat: begin
                sayac_d = '0;
                durum_d = StBekle;
            end
            StBekle: begin
                sayac_d = sayac_q + SayacW'(1);
                // First wait cycle is masked: the unit may still show ready from its last job
                if (sec_hazir && (sayac_q != '0)) begin
                    sonuc_d   = sec_sonuc;
                    gecerli_d = sec_gecerli;
                    tasma_d   = sec_tasma;
                    zaman_d   = 1'b0;
                    durum_d   = StCikis;
                end else if (sayac_q == SayacSon) begin
                    sonuc_d   = '0;
                    gecerli_d = 1'b0;
                    tasma_d   = 1'b0;
                    zaman_d   = 1'b1;
                    durum_d   = StCikis;
                end
            end
            StCikis: begin
                if (sonuc_al) begin
                    durum_d = StBosta;
                end
            end
            default: durum_d = StBosta;
        endcase

        hazir_d       = (durum_d == StCikis);
        istek_hazir_d = (durum_d == StBosta);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum_q       <= StBosta;
            sayac_q       <= '0;
            tur_q         <= '0;
            sayi1_q       <= '0;
            sayi2_q       <= '0;
            basla_q       <= '0;
            sonuc_q       <= '0;
            gecerli_q     <= 1'b0;
            tasma_q       <= 1'b0;
            zaman_q       <= 1'b0;
            hazir_q       <= 1'b0;
            istek_hazir_q <= 1'b0;
        end else begin
            durum_q       <= durum_d;
            sayac_q       <= sayac_d;
            tur_q         <= tur_d;
            sayi1_q       <= sayi1_d;
            sayi2_q       <= sayi2_d;
            basla_q       <= basla_d;
            sonuc_q       <= sonuc_d;
            gecerli_q     <= gecerli_d;
            tasma_q       <= tasma_d;
            zaman_q       <= zaman_d;
            hazir_q       <= hazir_d;
            istek_hazir_q <= istek_hazir_d;
        end
    end

    assign istek_hazir = istek_hazir_q;
    assign birim_sayi1 = sayi1_q;
    assign birim_sayi2 = sayi2_q;
    assign birim_basla = basla_q;
    assign sonuc       = sonuc_q;
    assign gecerli     = gecerli_q;
    assign tasma       = tasma_q;
    assign zaman_asimi = zaman_q;
    assign hazir       = hazir_q;

endmodule

// File: tb/tb_islem_denetleyici.sv
// Directed bench for islem_denetleyici with ZAMAN_ASIMI=16. Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_islem_denetleyici;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         istek_gecerli = 1'b0;
    logic         istek_hazir;
    logic [31:0]  sayi1 = '0;
    logic [31:0]  sayi2 = '0;
    logic [2:0]   tur = '0;
    logic [31:0]  birim_sayi1, birim_sayi2;
    logic [6:0]   birim_basla;
    logic [6:0]   birim_hazir = '0;
    logic [6:0]   birim_gecerli = '0;
    logic [6:0]   birim_tasma = '0;
    logic [447:0] birim_sonuc = '0;
    logic [63:0]  sonuc;
    logic         gecerli, tasma, zaman_asimi, hazir;
    logic         sonuc_al = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    islem_denetleyici #(.ZAMAN_ASIMI(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .istek_gecerli (istek_gecerli),
        .istek_hazir   (istek_hazir),
        .sayi1         (sayi1),
        .sayi2         (sayi2),
        .tur           (tur),
        .birim_sayi1   (birim_sayi1),
        .birim_sayi2   (birim_sayi2),
        .birim_basla   (birim_basla),
        .birim_hazir   (birim_hazir),
        .birim_gecerli (birim_gecerli),
        .birim_tasma   (birim_tasma),
        .birim_sonuc   (birim_sonuc),
        .sonuc         (sonuc),
        .gecerli       (gecerli),
        .tasma         (tasma),
        .zaman_asimi   (zaman_asimi),
        .hazir         (hazir),
        .sonuc_al      (sonuc_al)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; returns in cycle T+1 of the accept edge T
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] t);
        sayi1 = a;
        sayi2 = b;
        tur = t;
        istek_gecerli = 1'b1;
        cyc(1);
        istek_gecerli = 1'b0;
    endtask

    task automatic take();
        sonuc_al = 1'b1;
        cyc(1);
        sonuc_al = 1'b0;
        check("take_hazir", 64'(hazir), 64'd0);
        check("take_istek_hazir", 64'(istek_hazir), 64'd1);
    endtask

    task automatic unit_set(input int k, input logic [63:0] v, input logic g, input logic h);
        birim_hazir[k] = h;
        birim_gecerli[k] = g;
        birim_sonuc[64*k +: 64] = v;
    endtask

    initial begin
        // Reset
        cyc(2);
        check("rst_istek_hazir", 64'(istek_hazir), 64'd0);
        check("rst_hazir", 64'(hazir), 64'd0);
        check("rst_basla", 64'(birim_basla), 64'd0);
        rst = 1'b0;
        cyc(1);
        check("post_rst_istek_hazir", 64'(istek_hazir), 64'd1);

        // 1. add 5+7, unit answers 3 cycles after start
        send(32'd5, 32'd7, 3'b000);
        check("add_basla_t1", 64'(birim_basla), 64'h01);
        check("add_istek_hazir_t1", 64'(istek_hazir), 64'd0);
        check("add_sayi1", 64'(birim_sayi1), 64'd5);
        check("add_sayi2", 64'(birim_sayi2), 64'd7);
        cyc(1);
        check("add_basla_t2", 64'(birim_basla), 64'h00);
        cyc(2);
        check("add_hazir_t4", 64'(hazir), 64'd0);
        unit_set(0, 64'd12, 1'b1, 1'b1);
        cyc(1);
        check("add_hazir_t5", 64'(hazir), 64'd1);
        check("add_sonuc", sonuc, 64'd12);
        check("add_gecerli", 64'(gecerli), 64'd1);
        check("add_tasma", 64'(tasma), 64'd0);
        check("add_zaman", 64'(zaman_asimi), 64'd0);
        unit_set(0, 64'd0, 1'b0, 1'b0);
        take();

        // 2. invalid op code
        send(32'd9, 32'd9, 3'b111);
        check("inv_basla", 64'(birim_basla), 64'h00);
        check("inv_hazir_t1", 64'(hazir), 64'd1);
        check("inv_sonuc", sonuc, 64'd0);
        check("inv_gecerli", 64'(gecerli), 64'd0);
        check("inv_zaman", 64'(zaman_asimi), 64'd0);
        take();

        // 3. div never ready: timeout; the unit's junk result must not leak
        unit_set(3, 64'hDEAD, 1'b1, 1'b0);
        send(32'd1, 32'd0, 3'b011);
        check("div_basla", 64'(birim_basla), 64'h08);
        cyc(16);
        check("to_hazir_t17", 64'(hazir), 64'd0);
        cyc(1);
        check("to_hazir_t18", 64'(hazir), 64'd1);
        check("to_zaman", 64'(zaman_asimi), 64'd1);
        check("to_gecerli", 64'(gecerli), 64'd0);
        check("to_sonuc", sonuc, 64'd0);
        take();

        // 4. stale ready held through the first wait cycle, real answer at T+5
        unit_set(3, 64'd99, 1'b1, 1'b1);
        send(32'd6, 32'd2, 3'b011);
        cyc(2);
        unit_set(3, 64'd99, 1'b0, 1'b0);
        cyc(1);
        check("stale_hazir_t4", 64'(hazir), 64'd0);
        cyc(1);
        unit_set(3, 64'd3, 1'b1, 1'b1);
        cyc(1);
        check("stale_hazir_t6", 64'(hazir), 64'd1);
        check("stale_sonuc", sonuc, 64'd3);
        check("stale_zaman", 64'(zaman_asimi), 64'd0);
        unit_set(3, 64'd0, 1'b0, 1'b0);

        // 5. backpressure with a new request waiting
        sayi1 = 32'd1;
        sayi2 = 32'd1;
        tur = 3'b000;
        istek_gecerli = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("bp_istek_hazir", 64'(istek_hazir), 64'd0);
            check("bp_hazir", 64'(hazir), 64'd1);
            check("bp_sonuc", sonuc, 64'd3);
            check("bp_sayi1", 64'(birim_sayi1), 64'd6);
        end
        sonuc_al = 1'b1;
        cyc(1);
        sonuc_al = 1'b0;
        check("bp_idle_istek_hazir", 64'(istek_hazir), 64'd1);
        check("bp_idle_basla", 64'(birim_basla), 64'h00);
        cyc(1);
        istek_gecerli = 1'b0;
        check("bp_second_basla", 64'(birim_basla), 64'h01);
        check("bp_second_sayi1", 64'(birim_sayi1), 64'd1);
        cyc(2);
        unit_set(0, 64'd2, 1'b1, 1'b1);
        cyc(1);
        check("bp_second_hazir", 64'(hazir), 64'd1);
        check("bp_second_sonuc", sonuc, 64'd2);
        unit_set(0, 64'd0, 1'b0, 1'b0);
        take();

        // 6. reset during a mul wait, then a fresh add
        send(32'd3, 32'd4, 3'b010);
        cyc(2);
        rst = 1'b1;
        #1;
        check("mid_rst_istek_hazir", 64'(istek_hazir), 64'd0);
        check("mid_rst_sayi1", 64'(birim_sayi1), 64'd0);
        check("mid_rst_sonuc", sonuc, 64'd0);
        check("mid_rst_gecerli", 64'(gecerli), 64'd0);
        cyc(2);
        rst = 1'b0;
        unit_set(2, 64'd77, 1'b1, 1'b1);
        cyc(1);
        check("after_rst_istek_hazir", 64'(istek_hazir), 64'd1);
        check("after_rst_basla", 64'(birim_basla), 64'h00);
        check("after_rst_hazir", 64'(hazir), 64'd0);
        unit_set(2, 64'd0, 1'b0, 1'b0);
        send(32'd2, 32'd2, 3'b000);
        check("fresh_basla", 64'(birim_basla), 64'h01);
        cyc(2);
        unit_set(0, 64'd4, 1'b1, 1'b1);
        cyc(1);
        check("fresh_hazir", 64'(hazir), 64'd1);
        check("fresh_sonuc", sonuc, 64'd4);
        check("fresh_gecerli", 64'(gecerli), 64'd1);
        unit_set(0, 64'd0, 1'b0, 1'b0);
        take();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
